// File: rtl/updi_seq_pkg.sv
// Shared types and helpers for the multi-target UPDI batch sequencer.
package updi_seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSelect,
        StSettle,
        StLaunch,
        StWaitBusy,
        StRun,
        StEval,
        StDone
    } seq_state_e;

    localparam int unsigned MaxTargets = 256;
    localparam int unsigned LsbIdxW    = 8;

    typedef struct packed {
        logic               found;
        logic [LsbIdxW-1:0] idx;
    } lsb_t;

    // Priority search from the top so the last write wins with the lowest index.
    function automatic lsb_t lowest_set_index(input logic [MaxTargets-1:0] mask);
        lsb_t r;
        r.found = 1'b0;
        r.idx   = '0;
        for (int i = MaxTargets - 1; i >= 0; i--) begin
            if (mask[i]) begin
                r.found = 1'b1;
                r.idx   = LsbIdxW'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/updi_watchdog.sv
// Load/enable saturating cycle counter; hit_o flags the cycle in which the
// enabled count reaches Limit (the current cycle included).
module updi_watchdog #(
    parameter int unsigned Limit = 1,
    localparam int unsigned Width = $clog2(Limit + 1)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic en_i,
    output logic hit_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != Width'(Limit))) begin
            cnt_d = cnt_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_o = en_i && (cnt_q >= Width'(Limit - 1));

endmodule

// File: rtl/updi_multi_target_seq.sv
// Batch sequencer: walks the requested targets lowest-first, launching the
// shared programmer core per target with guard time, watchdog and retries.
module updi_multi_target_seq
    import updi_seq_pkg::*;
#(
    parameter int unsigned NUM_TARGETS    = 4,
    parameter int unsigned MAX_RETRIES    = 2,
    parameter int unsigned SETTLE_CYCLES  = 100,
    parameter int unsigned TIMEOUT_CYCLES = 16000000,
    localparam int unsigned CH_BITS = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [NUM_TARGETS-1:0] channel_mask,
    output logic                   busy,
    output logic                   done,
    output logic [NUM_TARGETS-1:0] pass_mask,
    output logic [NUM_TARGETS-1:0] fail_mask,
    output logic [NUM_TARGETS-1:0] chan_sel,
    output logic [CH_BITS-1:0]     current_channel,
    output logic                   prog_start,
    output logic                   prog_abort,
    input  logic                   prog_busy,
    input  logic                   prog_error
);

    localparam int unsigned AttW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    seq_state_e             state_q, state_d;
    logic [NUM_TARGETS-1:0] pend_q, pend_d;
    logic [NUM_TARGETS-1:0] pass_q, pass_d;
    logic [NUM_TARGETS-1:0] fail_q, fail_d;
    logic [CH_BITS-1:0]     cur_q, cur_d;
    logic [AttW-1:0]        att_q, att_d;
    logic                   err_q, err_d;
    logic                   settle_hit, wd_hit;
    lsb_t                   lsb;

    updi_watchdog #(
        .Limit (SETTLE_CYCLES)
    ) u_settle (
        .clk_i  (clk),
        .rst_i  (rst),
        .load_i (state_q != StSettle),
        .en_i   (state_q == StSettle),
        .hit_o  (settle_hit)
    );

    updi_watchdog #(
        .Limit (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i  (clk),
        .rst_i  (rst),
        .load_i (state_q == StLaunch),
        .en_i   ((state_q == StWaitBusy) || (state_q == StRun)),
        .hit_o  (wd_hit)
    );

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        pass_d     = pass_q;
        fail_d     = fail_q;
        cur_d      = cur_q;
        att_d      = att_q;
        err_d      = err_q;
        prog_abort = 1'b0;
        lsb        = lowest_set_index(MaxTargets'(pend_q));

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    pend_d  = channel_mask;
                    pass_d  = '0;
                    fail_d  = '0;
                    state_d = StSelect;
                end
            end
            StSelect: begin
                if (lsb.found) begin
                    pend_d  = pend_q & ~(NUM_TARGETS'(1) << lsb.idx);
                    cur_d   = CH_BITS'(lsb.idx);
                    att_d   = '0;
                    state_d = StSettle;
                end else begin
                    state_d = StDone;
                end
            end
            StSettle: begin
                if (settle_hit) state_d = StLaunch;
            end
            StLaunch: state_d = StWaitBusy;
            StWaitBusy: begin
                if (wd_hit) begin
                    prog_abort = 1'b1;
                    err_d      = 1'b1;
                    state_d    = StEval;
                end else if (prog_busy) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                // A completion landing on the limit cycle beats the watchdog.
                if (!prog_busy) begin
                    err_d   = prog_error;
                    state_d = StEval;
                end else if (wd_hit) begin
                    prog_abort = 1'b1;
                    err_d      = 1'b1;
                    state_d    = StEval;
                end
            end
            StEval: begin
                if (!err_q) begin
                    pass_d[cur_q] = 1'b1;
                    state_d       = StSelect;
                end else if (att_q < AttW'(MAX_RETRIES)) begin
                    att_d   = att_q + AttW'(1);
                    state_d = StSettle;
                end else begin
                    fail_d[cur_q] = 1'b1;
                    state_d       = StSelect;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            pend_q  <= '0;
            pass_q  <= '0;
            fail_q  <= '0;
            cur_q   <= '0;
            att_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            cur_q   <= cur_d;
            att_q   <= att_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        chan_sel = '0;
        if ((state_q == StSettle) || (state_q == StLaunch) || (state_q == StWaitBusy) ||
            (state_q == StRun) || (state_q == StEval)) begin
            chan_sel = NUM_TARGETS'(1) << cur_q;
        end
    end

    assign busy            = (state_q != StIdle);
    assign done            = (state_q == StDone);
    assign prog_start      = (state_q == StLaunch);
    assign pass_mask       = pass_q;
    assign fail_mask       = fail_q;
    assign current_channel = cur_q;

endmodule

// File: doc/updi_multi_target_seq.md
Name: updi_multi_target_seq

Overview:
- Batch sequencer that programs up to NUM_TARGETS UPDI targets in turn using one shared updi_programmer core.
- Sits between the board-level start/busy controls and the programmer.
- Selects one target line at a time and waits a guard interval before each attempt.
- Launches the core, supervises it with a watchdog, retries failed attempts, and reports per-target pass/fail masks.

Parameters:
NUM_TARGETS, 4, number of target UPDI channels (>=1)
MAX_RETRIES, 2, extra attempts per target after the first failure (0 = single attempt)
SETTLE_CYCLES, 100, guard cycles with chan_sel stable before each launch (>=1)
TIMEOUT_CYCLES, 16000000, watchdog limit in cycles from launch until prog_busy falls
CH_BITS, $clog2(NUM_TARGETS) with minimum 1, derived localparam, index width

Ports:
clk  input  1  system clock
rst  input  1  reset; synchronous, active-high
start  input  1  batch request; sampled only in IDLE
channel_mask  input  NUM_TARGETS  targets to program; captured on accepted start
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse when the batch ends
pass_mask  output  NUM_TARGETS  targets that completed without error
fail_mask  output  NUM_TARGETS  targets that exhausted their retries or timed out
chan_sel  output  NUM_TARGETS  one-hot enable for the active target's UPDI line driver; zero when no target is active
current_channel  output  CH_BITS  index of the active or last target
prog_start  output  1  one-cycle launch pulse to the programmer core
prog_abort  output  1  one-cycle pulse on watchdog expiry; resets the core
prog_busy  input  1  core running
prog_error  input  1  core failure flag; valid in the cycle prog_busy is sampled low after running

Behaviour:
- Reset: every output is 0 and the state is IDLE. Reset mid-batch abandons the batch, drops chan_sel at once and clears both masks.
- States: IDLE, SELECT, SETTLE, LAUNCH, WAIT_BUSY, RUN, EVAL, DONE.
- IDLE:
  - start=1 captures channel_mask into pend, clears pass_mask/fail_mask and moves to SELECT.
  - start is ignored in every other state.
- SELECT:
  - Picks the lowest set bit of pend, clears it, loads current_channel, resets the attempt counter, goes to SETTLE.
  - If pend is 0, goes to DONE.
  - chan_sel is 0 in SELECT.
- SETTLE: chan_sel is one-hot on current_channel. Holds exactly SETTLE_CYCLES cycles, then goes to LAUNCH.
- LAUNCH: prog_start=1 for this single cycle. Clears the watchdog counter, goes to WAIT_BUSY.
- WAIT_BUSY: waits for prog_busy=1, then goes to RUN.
- RUN: waits for prog_busy=0, samples prog_error in that same cycle, goes to EVAL.
- Watchdog:
  - Counts every cycle spent in WAIT_BUSY and RUN.
  - When the count reaches TIMEOUT_CYCLES, prog_abort pulses and the attempt is treated as an error.
  - If prog_busy falls in the same cycle the count reaches the limit, completion wins and prog_abort does not pulse.
- EVAL:
  - No error: set pass_mask[current_channel], go to SELECT.
  - Error with attempts < MAX_RETRIES: increment attempts, go to SETTLE (full guard interval again).
  - Otherwise: set fail_mask[current_channel], go to SELECT.
- DONE: done=1 for one cycle, then IDLE. pass_mask and fail_mask hold until the next accepted start.
- chan_sel is nonzero only in SETTLE, LAUNCH, WAIT_BUSY, RUN and EVAL, and is never more than one-hot.
- Latency:
  - Empty mask: busy is high for exactly 2 cycles (SELECT, DONE), with done in the second.
  - Per clean attempt, prog_start rises SETTLE_CYCLES+1 cycles after SELECT.
- Width rules:
  - Attempt counter is $clog2(MAX_RETRIES+1) bits, minimum 1.
  - Watchdog is $clog2(TIMEOUT_CYCLES+1) bits and saturates (no wrap).
  - Settle counter has no wrap.
- NUM_TARGETS=1: CH_BITS=1 and current_channel is always 0.

Decomposition:
- Package updi_seq_pkg holds:
  - the state enum typedef;
  - the helper function lowest_set_index(mask) returning the index plus a found flag.
- Sub-module updi_watchdog: a load/enable/saturating counter with an expired flag, reused for both SETTLE and timeout counting. Two instances; the parameter sets the limit.
- The top-level wrapper instantiates this block plus one updi_programmer, and gates each target's tri-state UPDI pad with chan_sel.

Test Plan (NUM_TARGETS=4, SETTLE_CYCLES=4, TIMEOUT_CYCLES=50, MAX_RETRIES=1; bench models the core):
- mask=4'b0101, core busy 10 cycles with no error on each launch -> targets 0 then 2, prog_start 5 cycles after each SELECT, pass_mask=0101, fail_mask=0000, exactly one done pulse.
- mask=4'b0000 -> busy high 2 cycles, done in the second, chan_sel stays 0, no prog_start.
- mask=4'b0010, error on the first run and clean on the second -> two prog_start pulses, chan_sel=0010 held throughout, pass_mask=0010.
- mask=4'b1000, error on every run -> 2 attempts, fail_mask=1000, then done.
- mask=4'b0001, core never raises prog_busy -> prog_abort pulses 50 cycles after LAUNCH, retry, second timeout, fail_mask=0001.
- rst asserted during RUN on target 1 with start held high -> next cycle all outputs 0; after rst is released, start is accepted and the masks are fresh.
